// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter sharing one RAM port among CHANNELS
// cache-side requesters. A grant is held until the RAM reports ACCESS, or until
// the owner withdraws its request. Every completion is followed by one IDLE
// arbitration cycle.
//
// Ports:
//   CLK, nRST           clock (rising edge), async active-low reset
//   reqREN/reqWEN       per-channel read/write enables
//   reqaddr/reqstore    per-channel address/write data, channel i at [i*W +: W]
//   reqwait             per-channel wait (0 = not requesting or completing now)
//   reqload             read data for the completing channel, else 0
//   grant               one-hot owner of the RAM port, 0 when idle
//   ramaddr/ramstore    RAM address/write data (owner's live request)
//   ramREN/ramWEN       RAM enables (write wins over read)
//   ramload/ramstate    RAM read data and state (FREE/BUSY/ACCESS/ERROR)
module ram_arbiter #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic [CHANNELS-1:0]          reqREN,
  input  logic [CHANNELS-1:0]          reqWEN,
  input  logic [CHANNELS*ADDR_W-1:0]   reqaddr,
  input  logic [CHANNELS*DATA_W-1:0]   reqstore,
  output logic [CHANNELS-1:0]          reqwait,
  output logic [DATA_W-1:0]            reqload,
  output logic [CHANNELS-1:0]          grant,
  output logic [ADDR_W-1:0]            ramaddr,
  output logic [DATA_W-1:0]            ramstore,
  output logic                         ramREN,
  output logic                         ramWEN,
  input  logic [DATA_W-1:0]            ramload,
  input  logic [1:0]                   ramstate
);

  localparam int unsigned IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [1:0]  RAM_ACCESS = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  logic [CHANNELS-1:0] req_c;
  logic [IDX_W-1:0]    pick_c;
  logic                pick_vld_c;
  logic [IDX_W-1:0]    next_ptr_c;

  logic [ADDR_W-1:0]   addr_a  [CHANNELS];
  logic [DATA_W-1:0]   store_a [CHANNELS];

  // Unpack the flat per-channel buses for indexing by owner.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_unpack
    assign addr_a[g]  = reqaddr[g*ADDR_W +: ADDR_W];
    assign store_a[g] = reqstore[g*DATA_W +: DATA_W];
  end

  assign req_c = reqREN | reqWEN;

  // Successor of the owner, wrapping at CHANNELS (which need not be a power of two).
  assign next_ptr_c = (owner_q == IDX_W'(CHANNELS - 1)) ? '0 : owner_q + IDX_W'(1);

  // First requesting channel scanning ptr, ptr+1, ... modulo CHANNELS.
  always_comb begin
    int unsigned idx;
    pick_vld_c = 1'b0;
    pick_c     = '0;
    idx        = 0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!pick_vld_c && req_c[IDX_W'(idx)]) begin
        pick_vld_c = 1'b1;
        pick_c     = IDX_W'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state and port drive. Outputs depend only on registered state and
  // live request inputs; ramstate/ramload reach only reqwait and reqload.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    grant    = '0;
    ramaddr  = '0;
    ramstore = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    reqload  = '0;
    reqwait  = req_c;

    case (state_q)
      IDLE: begin
        if (pick_vld_c) begin
          owner_d = pick_c;
          state_d = OWN;
        end
      end

      OWN: begin
        grant[owner_q] = 1'b1;
        ramaddr        = addr_a[owner_q];
        ramstore       = store_a[owner_q];
        ramWEN         = reqWEN[owner_q];
        ramREN         = reqREN[owner_q] & ~reqWEN[owner_q];
        if (!req_c[owner_q]) begin
          // Owner withdrew: release without a completion pulse.
          state_d = IDLE;
          ptr_d   = next_ptr_c;
        end else if (ramstate == RAM_ACCESS) begin
          reqwait[owner_q] = 1'b0;
          reqload          = ramload;
          state_d          = IDLE;
          ptr_d            = next_ptr_c;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
